// File: rtl/ex_mem_stage_reg.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_reg
//
// EX -> MEM pipeline register with stall/flush control and three saturating
// event counters (retired-into-MEM instructions, stall cycles, bubbles).
//
// Ports
//   clk, rst              : rising-edge clock, synchronous active-high reset
//   StallM                : hold the current MEM-stage contents
//   FlushM                : load a bubble (all zeros) instead of the EX contents
//   CntClr                : synchronous clear of the event counters only
//   *E inputs / *M outputs: ValidE, ALUResultE, WriteDataE, PCPlus4E,
//                           MemWriteE, MemReadE, RegWriteE, LS_modeE,
//                           ResultSrcE, RdE and their registered M copies
//   FwdValidM             : MEM-stage result eligible for forwarding
//   InstrCnt, StallCnt,
//   BubbleCnt             : saturating event counters
//
// Per-cycle priority: rst > FlushM > StallM > load.
// ---------------------------------------------------------------------------
module ex_mem_stage_reg #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      StallM,
    input  logic                      FlushM,
    input  logic                      CntClr,

    input  logic                      ValidE,
    input  logic [DATA_WIDTH-1:0]     ALUResultE,
    input  logic [DATA_WIDTH-1:0]     WriteDataE,
    input  logic [DATA_WIDTH-1:0]     PCPlus4E,
    input  logic                      MemWriteE,
    input  logic                      MemReadE,
    input  logic                      RegWriteE,
    input  logic [2:0]                LS_modeE,
    input  logic [1:0]                ResultSrcE,
    input  logic [REG_ADDR_WIDTH-1:0] RdE,

    output logic                      ValidM,
    output logic [DATA_WIDTH-1:0]     ALUResultM,
    output logic [DATA_WIDTH-1:0]     WriteDataM,
    output logic [DATA_WIDTH-1:0]     PCPlus4M,
    output logic                      MemWriteM,
    output logic                      MemReadM,
    output logic                      RegWriteM,
    output logic [2:0]                LS_modeM,
    output logic [1:0]                ResultSrcM,
    output logic [REG_ADDR_WIDTH-1:0] RdM,

    output logic                      FwdValidM,
    output logic [CNT_WIDTH-1:0]      InstrCnt,
    output logic [CNT_WIDTH-1:0]      StallCnt,
    output logic [CNT_WIDTH-1:0]      BubbleCnt
);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    logic                      valid_q,     valid_d;
    logic [DATA_WIDTH-1:0]     alu_q,       alu_d;
    logic [DATA_WIDTH-1:0]     wdata_q,     wdata_d;
    logic [DATA_WIDTH-1:0]     pc4_q,       pc4_d;
    logic                      memwr_q,     memwr_d;
    logic                      memrd_q,     memrd_d;
    logic                      regwr_q,     regwr_d;
    logic [2:0]                lsmode_q,    lsmode_d;
    logic [1:0]                ressrc_q,    ressrc_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q,        rd_d;
    logic [CNT_WIDTH-1:0]      instr_cnt_q, instr_cnt_d;
    logic [CNT_WIDTH-1:0]      stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0]      bubble_cnt_q, bubble_cnt_d;

    logic load;

    always_comb begin
        load = !FlushM && !StallM;

        valid_d  = valid_q;
        alu_d    = alu_q;
        wdata_d  = wdata_q;
        pc4_d    = pc4_q;
        memwr_d  = memwr_q;
        memrd_d  = memrd_q;
        regwr_d  = regwr_q;
        lsmode_d = lsmode_q;
        ressrc_d = ressrc_q;
        rd_d     = rd_q;

        // Flush overrides stall: the bubble is all-zero so no strobe survives.
        if (FlushM) begin
            valid_d  = 1'b0;
            alu_d    = '0;
            wdata_d  = '0;
            pc4_d    = '0;
            memwr_d  = 1'b0;
            memrd_d  = 1'b0;
            regwr_d  = 1'b0;
            lsmode_d = '0;
            ressrc_d = '0;
            rd_d     = '0;
        end else if (load) begin
            valid_d  = ValidE;
            alu_d    = ALUResultE;
            wdata_d  = WriteDataE;
            pc4_d    = PCPlus4E;
            memwr_d  = MemWriteE;
            memrd_d  = MemReadE;
            regwr_d  = RegWriteE;
            lsmode_d = LS_modeE;
            ressrc_d = ResultSrcE;
            rd_d     = RdE;
        end

        instr_cnt_d  = instr_cnt_q;
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;

        // Clear takes precedence over any increment in the same cycle.
        if (CntClr) begin
            instr_cnt_d  = '0;
            stall_cnt_d  = '0;
            bubble_cnt_d = '0;
        end else begin
            if (load && ValidE) begin
                instr_cnt_d = sat_inc(instr_cnt_q);
            end
            if (StallM && !FlushM) begin
                stall_cnt_d = sat_inc(stall_cnt_q);
            end
            if (FlushM) begin
                bubble_cnt_d = sat_inc(bubble_cnt_q);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= 1'b0;
            alu_q        <= '0;
            wdata_q      <= '0;
            pc4_q        <= '0;
            memwr_q      <= 1'b0;
            memrd_q      <= 1'b0;
            regwr_q      <= 1'b0;
            lsmode_q     <= '0;
            ressrc_q     <= '0;
            rd_q         <= '0;
            instr_cnt_q  <= '0;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            valid_q      <= valid_d;
            alu_q        <= alu_d;
            wdata_q      <= wdata_d;
            pc4_q        <= pc4_d;
            memwr_q      <= memwr_d;
            memrd_q      <= memrd_d;
            regwr_q      <= regwr_d;
            lsmode_q     <= lsmode_d;
            ressrc_q     <= ressrc_d;
            rd_q         <= rd_d;
            instr_cnt_q  <= instr_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ValidM     = valid_q;
    assign ALUResultM = alu_q;
    assign WriteDataM = wdata_q;
    assign PCPlus4M   = pc4_q;
    assign MemWriteM  = memwr_q;
    assign MemReadM   = memrd_q;
    assign RegWriteM  = regwr_q;
    assign LS_modeM   = lsmode_q;
    assign ResultSrcM = ressrc_q;
    assign RdM        = rd_q;

    // x0 is hard-wired zero, so a write to it is never worth forwarding.
    assign FwdValidM = valid_q && regwr_q && (rd_q != '0);

    assign InstrCnt  = instr_cnt_q;
    assign StallCnt  = stall_cnt_q;
    assign BubbleCnt = bubble_cnt_q;

endmodule
